// File: rtl/fwd_pipe.sv
// Dual-slot EX->LSU->WB pipeline registers and bypass sources.
// Optional retire counters under `FWD_PERF_CNT_EN`.
module fwd_pipe #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            kill1_i,
    input  logic            valid0_i,
    input  logic            valid1_i,
    input  logic            rd_we0_i,
    input  logic            rd_we1_i,
    input  logic [AW-1:0]   rd0_i,
    input  logic [AW-1:0]   rd1_i,
    input  logic            is_load0_i,
    input  logic            is_load1_i,
    input  logic [XLEN-1:0] alu0_i,
    input  logic [XLEN-1:0] alu1_i,
    input  logic [XLEN-1:0] ld_data0_i,
    input  logic [XLEN-1:0] ld_data1_i,
    output logic            wm0_o,
    output logic            wm1_o,
    output logic [AW-1:0]   am0_o,
    output logic [AW-1:0]   am1_o,
    output logic [XLEN-1:0] bypass_lsu0_o,
    output logic [XLEN-1:0] bypass_lsu1_o,
    output logic            ww0_o,
    output logic            ww1_o,
    output logic [AW-1:0]   aw0_o,
    output logic [AW-1:0]   aw1_o,
    output logic [XLEN-1:0] bypass_wb0_o,
    output logic [XLEN-1:0] bypass_wb1_o,
    output logic            rf_we0_o,
    output logic            rf_we1_o,
    output logic [AW-1:0]   rf_wa0_o,
    output logic [AW-1:0]   rf_wa1_o,
    output logic [XLEN-1:0] rf_wd0_o,
    output logic [XLEN-1:0] rf_wd1_o,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]     retired0_o,
    output logic [31:0]     retired1_o,
`endif
    output logic            ld_use_o
);

    logic [AW-1:0]   ex_rd   [2];
    logic [XLEN-1:0] ex_alu  [2];
    logic [XLEN-1:0] ex_ldd  [2];
    logic [1:0]      ex_we;
    logic [1:0]      ex_ld;

    assign ex_rd[0]  = rd0_i;
    assign ex_rd[1]  = rd1_i;
    assign ex_alu[0] = alu0_i;
    assign ex_alu[1] = alu1_i;
    assign ex_ldd[0] = ld_data0_i;
    assign ex_ldd[1] = ld_data1_i;
    assign ex_we     = {rd_we1_i, rd_we0_i};
    assign ex_ld     = {is_load1_i, is_load0_i};

    logic [1:0]      lsu_v_q, lsu_v_d;
    logic [1:0]      lsu_we_q, lsu_we_d;
    logic [1:0]      lsu_ld_q;
    logic [AW-1:0]   lsu_rd_q   [2];
    logic [XLEN-1:0] lsu_alu_q  [2];
    logic [1:0]      wb_v_q, wb_we_q;
    logic [AW-1:0]   wb_rd_q    [2];
    logic [XLEN-1:0] wb_data_q  [2];
    logic [XLEN-1:0] wb_data_d  [2];

    // Capture qualifiers: flush/kill drop slots, x0 writes never enable.
    always_comb begin
        lsu_v_d[0] = valid0_i & ~flush_i;
        lsu_v_d[1] = valid1_i & ~flush_i & ~kill1_i;
        for (int n = 0; n < 2; n++) begin
            lsu_we_d[n]  = ex_we[n] & (ex_rd[n] != '0);
            wb_data_d[n] = lsu_ld_q[n] ? ex_ldd[n] : lsu_alu_q[n];
        end
    end

    // LSU and WB stage registers; reset wins over stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lsu_v_q  <= '0;
            lsu_we_q <= '0;
            lsu_ld_q <= '0;
            wb_v_q   <= '0;
            wb_we_q  <= '0;
            for (int n = 0; n < 2; n++) begin
                lsu_rd_q[n]  <= '0;
                lsu_alu_q[n] <= '0;
                wb_rd_q[n]   <= '0;
                wb_data_q[n] <= '0;
            end
        end else if (!stall_i) begin
            lsu_v_q  <= lsu_v_d;
            lsu_we_q <= lsu_we_d;
            lsu_ld_q <= ex_ld;
            wb_v_q   <= lsu_v_q;
            wb_we_q  <= lsu_we_q;
            for (int n = 0; n < 2; n++) begin
                lsu_rd_q[n]  <= ex_rd[n];
                lsu_alu_q[n] <= ex_alu[n];
                wb_rd_q[n]   <= lsu_rd_q[n];
                wb_data_q[n] <= wb_data_d[n];
            end
        end
    end

    logic [1:0] lsu_wr, lsu_fw, wb_wr;
    logic       lsu_same, wb_same;

    // Bypass qualifiers; the younger slot 1 shadows slot 0 on equal rd.
    always_comb begin
        lsu_wr   = lsu_v_q & lsu_we_q;
        lsu_fw   = lsu_wr & ~lsu_ld_q;
        wb_wr    = wb_v_q & wb_we_q;
        lsu_same = lsu_wr[1] & (lsu_rd_q[0] == lsu_rd_q[1]);
        wb_same  = wb_wr[1] & (wb_rd_q[0] == wb_rd_q[1]);
    end

    assign wm0_o         = lsu_fw[0] & ~lsu_same;
    assign wm1_o         = lsu_fw[1];
    assign am0_o         = lsu_rd_q[0];
    assign am1_o         = lsu_rd_q[1];
    assign bypass_lsu0_o = lsu_alu_q[0];
    assign bypass_lsu1_o = lsu_alu_q[1];
    assign ld_use_o      = |(lsu_wr & lsu_ld_q);

    assign ww0_o         = wb_wr[0] & ~wb_same;
    assign ww1_o         = wb_wr[1];
    assign aw0_o         = wb_rd_q[0];
    assign aw1_o         = wb_rd_q[1];
    assign bypass_wb0_o  = wb_data_q[0];
    assign bypass_wb1_o  = wb_data_q[1];
    assign rf_we0_o      = ww0_o;
    assign rf_we1_o      = ww1_o;
    assign rf_wa0_o      = wb_rd_q[0];
    assign rf_wa1_o      = wb_rd_q[1];
    assign rf_wd0_o      = wb_data_q[0];
    assign rf_wd1_o      = wb_data_q[1];

`ifdef FWD_PERF_CNT_EN
    logic [31:0] ret0_q, ret1_q;

    // Count instructions leaving WB on unstalled edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ret0_q <= '0;
            ret1_q <= '0;
        end else if (!stall_i) begin
            ret0_q <= ret0_q + {31'd0, wb_v_q[0]};
            ret1_q <= ret1_q + {31'd0, wb_v_q[1]};
        end
    end

    assign retired0_o = ret0_q;
    assign retired1_o = ret1_q;
`endif

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed bench for fwd_pipe bypass/writeback pipeline.
// Drives after each edge, checks #1 after the edge.
module tb_fwd_pipe;

    logic        clk = 1'b0;
    logic        rst, stall, flush, kill1;
    logic        v0, v1, we0, we1, ld0, ld1;
    logic [4:0]  rd0, rd1;
    logic [31:0] alu0, alu1, ldd0, ldd1;
    logic        wm0, wm1, ww0, ww1, rfwe0, rfwe1, ld_use;
    logic [4:0]  am0, am1, aw0, aw1, rfwa0, rfwa1;
    logic [31:0] bl0, bl1, bw0, bw1, rfwd0, rfwd1;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] ret0, ret1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_pipe dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .flush_i(flush), .kill1_i(kill1),
        .valid0_i(v0), .valid1_i(v1),
        .rd_we0_i(we0), .rd_we1_i(we1),
        .rd0_i(rd0), .rd1_i(rd1),
        .is_load0_i(ld0), .is_load1_i(ld1),
        .alu0_i(alu0), .alu1_i(alu1),
        .ld_data0_i(ldd0), .ld_data1_i(ldd1),
        .wm0_o(wm0), .wm1_o(wm1),
        .am0_o(am0), .am1_o(am1),
        .bypass_lsu0_o(bl0), .bypass_lsu1_o(bl1),
        .ww0_o(ww0), .ww1_o(ww1),
        .aw0_o(aw0), .aw1_o(aw1),
        .bypass_wb0_o(bw0), .bypass_wb1_o(bw1),
        .rf_we0_o(rfwe0), .rf_we1_o(rfwe1),
        .rf_wa0_o(rfwa0), .rf_wa1_o(rfwa1),
        .rf_wd0_o(rfwd0), .rf_wd1_o(rfwd1),
`ifdef FWD_PERF_CNT_EN
        .retired0_o(ret0), .retired1_o(ret1),
`endif
        .ld_use_o(ld_use)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; we0 = 0; we1 = 0;
        ld0 = 0; ld1 = 0; rd0 = 0; rd1 = 0;
        alu0 = 0; alu1 = 0; ldd0 = 0; ldd1 = 0;
        flush = 0; kill1 = 0; stall = 0;
    endtask

    task automatic op0(input logic [4:0] r,
                       input logic [31:0] a);
        v0 = 1; we0 = 1; rd0 = r; alu0 = a;
    endtask

    task automatic op1(input logic [4:0] r,
                       input logic [31:0] a);
        v1 = 1; we1 = 1; rd1 = r; alu1 = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] others();
        return {31'd0, |{wm0, wm1, ww1, rfwe1, ld_use,
                         am0, am1, aw1, bl0, bl1, bw1,
                         rfwa1, rfwd1}};
    endfunction

    initial begin
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        chk("rst_wm", {30'd0, wm1, wm0}, 0);
        chk("rst_ww", {28'd0, rfwe1, rfwe0, ww1, ww0}, 0);
        chk("rst_addr", {12'd0, am0, am1, aw0, aw1}, 0);
        chk("rst_data", bl0 | bl1 | bw0 | bw1, 0);
        chk("rst_ld_use", {31'd0, ld_use}, 0);

        // single slot-0 ALU op
        op0(5'd5, 32'h1234);
        step();
        idle();
        chk("t1_wm0", {31'd0, wm0}, 1);
        chk("t1_am0", {27'd0, am0}, 5);
        chk("t1_bl0", bl0, 32'h1234);
        step();
        chk("t1_ww0", {30'd0, rfwe0, ww0}, 3);
        chk("t1_rfwa0", {27'd0, rfwa0}, 5);
        chk("t1_rfwd0", rfwd0, 32'h1234);
        chk("t1_others", others(), 0);

        // slot-1 load
        op1(5'd7, 32'h0);
        ld1 = 1;
        step();
        idle();
        ldd1 = 32'hCAFE;
        chk("t2_wm1", {31'd0, wm1}, 0);
        chk("t2_ld_use", {31'd0, ld_use}, 1);
        step();
        idle();
        chk("t2_ww1", {31'd0, ww1}, 1);
        chk("t2_aw1", {27'd0, aw1}, 7);
        chk("t2_bw1", bw1, 32'hCAFE);
        chk("t2_ld_use_off", {31'd0, ld_use}, 0);

        // same rd in both slots
        op0(5'd3, 32'h11);
        op1(5'd3, 32'h22);
        step();
        idle();
        chk("t3_wm", {30'd0, wm1, wm0}, 2);
        chk("t3_bl1", bl1, 32'h22);
        step();
        chk("t3_rfwe", {30'd0, rfwe1, rfwe0}, 2);
        chk("t3_ww", {30'd0, ww1, ww0}, 2);
        chk("t3_rfwd1", rfwd1, 32'h22);

        // x0 destination
        op0(5'd0, 32'hFFFF_FFFF);
        op1(5'd0, 32'hFFFF_FFFF);
        step();
        idle();
        chk("t4_wm", {30'd0, wm1, wm0}, 0);
        step();
        chk("t4_ww", {28'd0, rfwe1, rfwe0, ww1, ww0}, 0);

        // stall with mid-stall flush
        op0(5'd9, 32'h99);
        step();
        op0(5'd10, 32'hAA);
        step();
        op0(5'd11, 32'hBB);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            step();
            chk("t5_hold_lsu",
                {wm0, 26'd0, am0}, {1'b1, 26'd0, 5'd10});
            chk("t5_hold_wb",
                {ww0, rfwe0, 25'd0, aw0}, {2'b11, 25'd0, 5'd9});
            chk("t5_hold_wd", rfwd0, 32'h99);
        end
        stall = 0;
        flush = 0;
        step();
        idle();
        chk("t5_rel_lsu", {wm0, 26'd0, am0}, {1'b1, 26'd0, 5'd11});
        chk("t5_rel_wb", rfwd0, 32'hAA);
        step();
        chk("t5_rel_wb2", rfwd0, 32'hBB);
        step();

        // kill1 then flush
        op0(5'd12, 32'h12);
        op1(5'd13, 32'h13);
        kill1 = 1;
        step();
        idle();
        op0(5'd14, 32'h14);
        op1(5'd15, 32'h15);
        flush = 1;
        chk("t6_wm_kill", {30'd0, wm1, wm0}, 1);
        step();
        idle();
        chk("t6_wm_flush", {30'd0, wm1, wm0}, 0);
        chk("t6_ww", {30'd0, ww1, ww0}, 1);
        chk("t6_aw0", {27'd0, aw0}, 12);
        step();
        chk("t6_ww_flush", {30'd0, ww1, ww0}, 0);

        // reset mid-pipeline
        op0(5'd20, 32'h2020);
        step();
        op0(5'd21, 32'h2121);
        step();
        idle();
        rst = 1;
        step();
        rst = 0;
        chk("t7_wm_ww", {30'd0, wm0, ww0}, 0);
        chk("t7_data", bl0 | bw0 | rfwd0, 0);
        chk("t7_addr", {22'd0, am0, aw0}, 0);

`ifdef FWD_PERF_CNT_EN
        chk("pc_rst", ret0, 0);
        for (int i = 0; i < 4; i++) begin
            op0(5'(i + 1), 32'(i));
            step();
        end
        idle();
        step();
        stall = 1;
        step();
        stall = 0;
        for (int i = 0; i < 4; i++) step();
        chk("pc_ret0", ret0, 4);
        chk("pc_ret1", ret1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
